// File: rtl/score_text_gen.sv
// Binary score to DIGITS-character ASCII vector for the text renderer.
// Iterative double-dabble (one shift per clock) feeding a double-buffered output.
module score_text_gen #(
  parameter int DIGITS  = 4,
  parameter int SCORE_W = 14
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  input  logic               blank_lz,
  output logic [6:0]         textVec [DIGITS],
  output logic               busy,
  output logic               done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam int CMP_W = (SCORE_W + 4 > 21) ? SCORE_W + 4 : 21;

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  localparam int               MAX_DEC = pow10(DIGITS) - 1;
  localparam logic [CMP_W-1:0] MAX_CMP = CMP_W'(MAX_DEC);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FORMAT} state_t;

  state_t             r_state;
  logic [SCORE_W-1:0] r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_blank;

  logic [SCORE_W-1:0] w_score_sat;
  logic [BCD_W-1:0]   w_bcd_adj;
  logic [6:0]         w_text [DIGITS];
  logic               w_lead;
  logic [3:0]         w_nib;

  // The saturated value is only selected when it is below the input range,
  // so narrowing MAX_DEC to SCORE_W bits never loses information.
  always_comb begin
    if (CMP_W'(score) > MAX_CMP) w_score_sat = SCORE_W'(MAX_DEC);
    else                         w_score_sat = score;
  end

  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      else                         w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4];
    end
  end

  // NOTE: every always_comb output gets a value on every path (w_lead is
  // seeded before the loop), otherwise synthesis infers latches.
  always_comb begin
    w_lead = r_blank;
    w_nib  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_nib = r_bcd[4*(DIGITS-1-i) +: 4];
      if (w_lead && (w_nib == 4'd0) && (i != DIGITS - 1)) begin
        w_text[i] = 7'h20;
      end else begin
        w_lead    = 1'b0;
        w_text[i] = 7'h30 + {3'b000, w_nib};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_blank <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      // NOTE: the output array is plain flops, not RAM, so it can and must be
      // reset to a defined "all zeros" display.
      for (int i = 0; i < DIGITS; i++) textVec[i] <= 7'h30;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin   <= w_score_sat;
            r_blank <= blank_lz;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(SCORE_W);
            busy    <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_FORMAT;
        end
        S_FORMAT: begin
          for (int i = 0; i < DIGITS; i++) textVec[i] <= w_text[i];
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_text_gen.sv
// Scoreboard bench for score_text_gen: stimulus pushes expected text vectors,
// a negedge monitor pops and compares them whenever done is presented.
module tb_score_text_gen;

  localparam int DIGITS  = 4;
  localparam int SCORE_W = 14;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               start;
  logic [SCORE_W-1:0] score;
  logic               blank_lz;
  logic [6:0]         textVec [DIGITS];
  logic               busy;
  logic               done;

  score_text_gen #(.DIGITS(DIGITS), .SCORE_W(SCORE_W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .start    (start),
    .score    (score),
    .blank_lz (blank_lz),
    .textVec  (textVec),
    .busy     (busy),
    .done     (done)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;
  logic [7*DIGITS-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7*DIGITS-1:0] pack_text();
    logic [7*DIGITS-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[7*(DIGITS-1-i) +: 7] = textVec[i];
    return v;
  endfunction

  function automatic logic [27:0] t4(input logic [7:0] a, input logic [7:0] b,
                                     input logic [7:0] c, input logic [7:0] d);
    return {a[6:0], b[6:0], c[6:0], d[6:0]};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (!Reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got %0h expected none at %0t", pack_text(), $time);
      end else begin
        check("text_vec", 64'(pack_text()), 64'(exp_q.pop_front()));
      end
    end
  end

  // Waits (bounded) for done after an accepting edge; counts busy cycles and
  // verifies textVec holds its previous value until the update edge.
  // An optional extra start pulse (with a different score) is issued at loop index pulse_at.
  task automatic wait_done(input logic [27:0] hold, input int pulse_at,
                           output int busy_cnt, output bit seen, output bit hold_ok);
    busy_cnt = 0;
    seen     = 1'b0;
    hold_ok  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k == pulse_at) begin
        start = 1'b1;
        score = 14'd8888;
      end else if (k == pulse_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (pack_text() !== hold) hold_ok = 1'b0;
      @(negedge Clk);
    end
    start = 1'b0;
  endtask

  task automatic do_conv(input int sc, input bit bl, input logic [27:0] exp, input int pulse_at);
    int          busy_cnt;
    bit          seen;
    bit          hold_ok;
    logic [27:0] hold;
    hold = pack_text();
    @(negedge Clk);
    start    = 1'b1;
    score    = SCORE_W'(sc);
    blank_lz = bl;
    exp_q.push_back(exp);
    @(negedge Clk);
    start = 1'b0;
    wait_done(hold, pulse_at, busy_cnt, seen, hold_ok);
    check("done_seen", 64'(seen), 64'd1);
    check("busy_cycles", 64'(busy_cnt), 64'd15);
    check("busy_low_at_done", 64'(busy), 64'd0);
    check("text_held", 64'(hold_ok), 64'd1);
    @(negedge Clk);
    check("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    int done_edges [$];
    int busy_cnt;
    bit seen;
    bit hold_ok;

    Reset    = 1'b1;
    start    = 1'b0;
    score    = '0;
    blank_lz = 1'b0;
    repeat (2) @(negedge Clk);
    check("reset_text", 64'(pack_text()), 64'(t4(8'h30, 8'h30, 8'h30, 8'h30)));
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    Reset = 1'b0;

    do_conv(1234,  1'b0, t4(8'h31, 8'h32, 8'h33, 8'h34), -10);
    do_conv(42,    1'b1, t4(8'h20, 8'h20, 8'h34, 8'h32), -10);
    do_conv(0,     1'b1, t4(8'h20, 8'h20, 8'h20, 8'h30), -10);
    do_conv(0,     1'b0, t4(8'h30, 8'h30, 8'h30, 8'h30), -10);
    do_conv(12000, 1'b0, t4(8'h39, 8'h39, 8'h39, 8'h39), -10);
    do_conv(9999,  1'b0, t4(8'h39, 8'h39, 8'h39, 8'h39), -10);
    do_conv(1000,  1'b1, t4(8'h31, 8'h30, 8'h30, 8'h30), -10);

    // Ignored start pulse during a conversion; textVec keeps 1234's codes meanwhile.
    do_conv(1234,  1'b0, t4(8'h31, 8'h32, 8'h33, 8'h34), -10);
    do_conv(567,   1'b0, t4(8'h30, 8'h35, 8'h36, 8'h37), 4);

    // start held high for 40 edges: done after edges 15 and 31, third conversion in flight.
    for (int j = 0; j < 3; j++) exp_q.push_back(t4(8'h30, 8'h30, 8'h37, 8'h37));
    start    = 1'b1;
    score    = 14'd77;
    blank_lz = 1'b0;
    for (int e = 0; e < 40; e++) begin
      @(negedge Clk);
      if (done) done_edges.push_back(e);
    end
    start = 1'b0;
    check("held_done_count", 64'(done_edges.size()), 64'd2);
    if (done_edges.size() == 2) begin
      check("held_done_edge0", 64'(done_edges[0]), 64'd15);
      check("held_done_edge1", 64'(done_edges[1]), 64'd31);
    end
    wait_done(t4(8'h30, 8'h30, 8'h37, 8'h37), -10, busy_cnt, seen, hold_ok);
    check("held_third_done", 64'(seen), 64'd1);
    check("held_text_stable", 64'(hold_ok), 64'd1);
    @(negedge Clk);

    // Reset in cycle 7 of a conversion discards it immediately.
    start = 1'b1;
    score = 14'd4321;
    @(negedge Clk);
    start = 1'b0;
    repeat (6) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("midreset_text", 64'(pack_text()), 64'(t4(8'h30, 8'h30, 8'h30, 8'h30)));
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    @(negedge Clk);
    Reset = 1'b0;
    do_conv(4321, 1'b0, t4(8'h34, 8'h33, 8'h32, 8'h31), -10);

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
